irq_controller: RTL and testbench



---
 rtl/irq_pkg.sv | 43 ++++
 rtl/irq_controller_if.sv | 14 +
 rtl/irq_edge_sync.sv | 37 +++
 rtl/irq_controller.sv | 127 ++++++++++++
 tb/tb_irq_controller.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: IRQ codes, register map,
// FSM state encoding, source indices and priority helpers.
package irq_pkg;

  localparam logic [1:0] IRQ_NONE  = 2'b00;
  localparam logic [1:0] IRQ_TIMER = 2'b01;
  localparam logic [1:0] IRQ_RX    = 2'b10;
  localparam logic [1:0] IRQ_TX    = 2'b11;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_STATS   = 2'd3;

  localparam int unsigned SRC_TIMER = 0;
  localparam int unsigned SRC_RX    = 1;
  localparam int unsigned SRC_TX    = 2;
  localparam int unsigned NUM_SRC   = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DISPATCH = 2'b01,
    SERVICE  = 2'b10
  } state_e;

  // Fixed priority: timer > rx > tx; code is source index + 1.
  function automatic logic [1:0] prio_code(input logic [2:0] elig);
    if (elig[SRC_TIMER])   return IRQ_TIMER;
    else if (elig[SRC_RX]) return IRQ_RX;
    else if (elig[SRC_TX]) return IRQ_TX;
    else                   return IRQ_NONE;
  endfunction

  function automatic logic [2:0] code_onehot(input logic [1:0] code);
    case (code)
      IRQ_TIMER: return 3'b001;
      IRQ_RX:    return 3'b010;
      IRQ_TX:    return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Peripheral-bus config/status port of the interrupt controller.
//   cfg_we    write strobe
//   cfg_addr  register select
//   cfg_wdata write data
//   cfg_rdata read data (combinational from cfg_addr)
interface irq_controller_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  modport master (output cfg_we, output cfg_addr, output cfg_wdata, input cfg_rdata);
  modport slave  (input cfg_we, input cfg_addr, input cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/irq_edge_sync.sv
// One event line: SYNC_STAGES-deep synchronizer followed by a rising-edge
// detector producing a single-cycle pulse.
//   clk, reset  clock, synchronous active-high reset
//   evt_i       asynchronous event line
//   pulse_o     one-cycle pulse on a synchronized rising edge
module irq_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic evt_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;

  if (SYNC_STAGES == 1) begin : g_one
    assign sync_d = evt_i;
  end else begin : g_multi
    assign sync_d = {sync_q[SYNC_STAGES-2:0], evt_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller for the single-cycle MIPS core. Latches three event
// lines as pending, applies mask and fixed priority, and delivers one 2-bit
// IRQ code per kernel entry (monin), with no nesting.
//   clk, reset  clock, synchronous active-high reset
//   src_evt     event lines (0 timer, 1 UART rx, 2 UART tx), rising edge
//   monin       CPU kernel-mode flag
//   irq_code    registered IRQ code to the decoder
//   cfg         config/status bus port (irq_controller_if.slave)
// Optional: define IRQ_STATS_EN for per-source 16-bit delivery counters.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [2:0]  RESET_MASK  = 3'b000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      src_evt,
  input  logic            monin,
  output logic [1:0]      irq_code,
  irq_controller_if.slave cfg
);

  state_e     state_q;
  logic [1:0] irq_code_q;
  logic [1:0] in_service_q;
  logic [2:0] pending_q, pending_d;
  logic [2:0] mask_q;

  logic [2:0] evt_pulse;
  logic [2:0] eligible;
  logic [2:0] w1c;
  logic [2:0] svc_clr;
  logic       mask_we;
  logic       svc_entry;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset   (reset),
      .evt_i   (src_evt[g]),
      .pulse_o (evt_pulse[g])
    );
  end

  always_comb begin
    mask_we   = cfg.cfg_we && (cfg.cfg_addr == ADDR_MASK);
    w1c       = (cfg.cfg_we && (cfg.cfg_addr == ADDR_PENDING)) ? cfg.cfg_wdata[2:0] : '0;
    svc_entry = (state_q == DISPATCH) && monin;
    svc_clr   = svc_entry ? code_onehot(in_service_q) : '0;
    // New edges override any clear in the same cycle.
    pending_d = (pending_q & ~(w1c | svc_clr)) | evt_pulse;
    eligible  = pending_q & mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_code_q   <= IRQ_NONE;
      in_service_q <= IRQ_NONE;
      pending_q    <= '0;
      mask_q       <= RESET_MASK;
    end else begin
      pending_q <= pending_d;
      if (mask_we) mask_q <= cfg.cfg_wdata[2:0];
      case (state_q)
        IDLE: begin
          if ((eligible != '0) && !monin) begin
            irq_code_q   <= prio_code(eligible);
            in_service_q <= prio_code(eligible);
            state_q      <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (monin) begin
            irq_code_q <= IRQ_NONE;
            state_q    <= SERVICE;
          end
        end
        SERVICE: begin
          if (!monin) begin
            in_service_q <= IRQ_NONE;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq_code = irq_code_q;

`ifdef IRQ_STATS_EN
  logic [15:0] cnt_q [NUM_SRC];

  always_ff @(posedge clk) begin
    if (reset || (cfg.cfg_we && (cfg.cfg_addr == ADDR_STATS))) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++)
        if (svc_clr[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end
`endif

  always_comb begin
    cfg.cfg_rdata = '0;
    case (cfg.cfg_addr)
      ADDR_MASK:    cfg.cfg_rdata[2:0] = mask_q;
      ADDR_PENDING: cfg.cfg_rdata[2:0] = pending_q;
      ADDR_STATUS: begin
        cfg.cfg_rdata[1:0] = in_service_q;
        cfg.cfg_rdata[3:2] = state_q;
`ifdef IRQ_STATS_EN
        cfg.cfg_rdata[31:16] = cnt_q[SRC_TX];
`endif
      end
      ADDR_STATS: begin
`ifdef IRQ_STATS_EN
        cfg.cfg_rdata = {cnt_q[SRC_RX], cnt_q[SRC_TIMER]};
`endif
      end
      default: cfg.cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a cycle table of stimulus and
// expected outputs plus hand-written corner sequences, checked through a
// queue of expected results.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] src_evt;
  logic       monin;
  logic [1:0] irq_code;

  irq_controller_if cfg_if();

  irq_controller #(.SYNC_STAGES(2), .RESET_MASK(3'b000)) dut (
    .clk      (clk),
    .reset    (reset),
    .src_evt  (src_evt),
    .monin    (monin),
    .irq_code (irq_code),
    .cfg      (cfg_if)
  );

  always #10 clk = ~clk;

`ifdef IRQ_STATS_EN
  localparam logic [31:0] STAT_CARE = 32'h0000_FFFF;
`else
  localparam logic [31:0] STAT_CARE = 32'hFFFF_FFFF;
`endif

  typedef struct {
    bit          is_irq;
    logic [1:0]  addr;
    logic [31:0] exp;
    logic [31:0] care;
    int          tag;
  } exp_t;

  typedef struct {
    logic [2:0]  evt;
    logic        mon;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  e_irq;
    logic [2:0]  e_mask;
    logic [2:0]  e_pend;
    logic [3:0]  e_stat;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[26];
  int   total = 0;
  int   bad   = 0;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [2:0] evt, input logic mon, input logic we,
                       input logic [1:0] addr, input logic [31:0] wdata);
    src_evt          = evt;
    monin            = mon;
    cfg_if.cfg_we    = we;
    cfg_if.cfg_addr  = addr;
    cfg_if.cfg_wdata = wdata;
  endtask

  task automatic step;
    tick();
    cfg_if.cfg_we = 1'b0;
  endtask

  task automatic exp_irq(input int tag, input logic [1:0] e);
    exp_t x;
    x.is_irq = 1'b1; x.addr = 2'd0; x.exp = {30'b0, e}; x.care = 32'h3; x.tag = tag;
    sbq.push_back(x);
  endtask

  task automatic exp_reg(input int tag, input logic [1:0] a, input logic [31:0] e,
                         input logic [31:0] care);
    exp_t x;
    x.is_irq = 1'b0; x.addr = a; x.exp = e; x.care = care; x.tag = tag;
    sbq.push_back(x);
  endtask

  task automatic exp_all(input int tag, input logic [1:0] irq, input logic [2:0] mask,
                         input logic [2:0] pend, input logic [3:0] stat);
    exp_irq(tag, irq);
    exp_reg(tag, 2'd0, {29'b0, mask}, 32'hFFFF_FFFF);
    exp_reg(tag, 2'd1, {29'b0, pend}, 32'hFFFF_FFFF);
    exp_reg(tag, 2'd2, {28'b0, stat}, STAT_CARE);
  endtask

  task automatic drain;
    exp_t        x;
    logic [31:0] act;
    string       nm;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      if (x.is_irq) begin
        act = {30'b0, irq_code};
        nm  = "irq_code";
      end else begin
        cfg_if.cfg_addr = x.addr;
        #1;
        act = cfg_if.cfg_rdata;
        nm  = $sformatf("rdata@%0d", x.addr);
      end
      total++;
      if ((act & x.care) !== (x.exp & x.care)) begin
        bad++;
        $display("FAIL %s tag=%0d got=%h want=%h", nm, x.tag, act & x.care, x.exp & x.care);
      end
    end
  endtask

  // Timer event with monin low: pending after 3 edges, code on the 4th.
  task automatic timer_pulse_to_pending;
    drive(3'b001, 1'b0, 1'b0, 2'd0, '0); step();
    drive(3'b000, 1'b0, 1'b0, 2'd0, '0); step();
    step();
  endtask

  initial begin
    //           evt     mon   we    addr  wdata  | irq   mask    pend    stat
    tbl[0]  = '{3'b000, 1'b0, 1'b1, 2'd0, 32'd7, 2'd0, 3'd7, 3'd0, 4'h0};
    tbl[1]  = '{3'b001, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd0, 4'h0};
    tbl[2]  = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd0, 4'h0};
    tbl[3]  = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd1, 4'h0};
    tbl[4]  = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd1, 3'd7, 3'd1, 4'h5};
    tbl[5]  = '{3'b000, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd0, 4'h9};
    tbl[6]  = '{3'b000, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd0, 4'h9};
    tbl[7]  = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd0, 4'h0};
    tbl[8]  = '{3'b110, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd0, 4'h0};
    tbl[9]  = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd0, 4'h0};
    tbl[10] = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd6, 4'h0};
    tbl[11] = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd2, 3'd7, 3'd6, 4'h6};
    tbl[12] = '{3'b000, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd4, 4'hA};
    tbl[13] = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd4, 4'h0};
    tbl[14] = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd3, 3'd7, 3'd4, 4'h7};
    tbl[15] = '{3'b000, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd0, 4'hB};
    tbl[16] = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd7, 3'd0, 4'h0};
    tbl[17] = '{3'b000, 1'b0, 1'b1, 2'd0, 32'd1, 2'd0, 3'd1, 3'd0, 4'h0};
    tbl[18] = '{3'b010, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd1, 3'd0, 4'h0};
    tbl[19] = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd1, 3'd0, 4'h0};
    tbl[20] = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd1, 3'd2, 4'h0};
    tbl[21] = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd1, 3'd2, 4'h0};
    tbl[22] = '{3'b000, 1'b0, 1'b1, 2'd0, 32'd3, 2'd0, 3'd3, 3'd2, 4'h0};
    tbl[23] = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd2, 3'd3, 3'd2, 4'h6};
    tbl[24] = '{3'b000, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 3'd3, 3'd0, 4'hA};
    tbl[25] = '{3'b000, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 3'd3, 3'd0, 4'h0};

    reset = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 2'd0, '0);
    step(); step();
    exp_all(0, 2'd0, 3'd0, 3'd0, 4'h0);
    drain();
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].evt, tbl[i].mon, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      exp_all(1 + i, tbl[i].e_irq, tbl[i].e_mask, tbl[i].e_pend, tbl[i].e_stat);
      step();
      drain();
    end

    // Event arrives while in kernel: latched, delivered only after monin drops.
    drive(3'b000, 1'b0, 1'b1, 2'd0, 32'd7); step();
    drive(3'b001, 1'b1, 1'b0, 2'd0, '0); step();
    drive(3'b000, 1'b1, 1'b0, 2'd0, '0); step();
    step();
    exp_all(100, 2'd0, 3'd7, 3'd1, 4'h0); drain();
    step();
    exp_all(101, 2'd0, 3'd7, 3'd1, 4'h0); drain();
    drive(3'b000, 1'b0, 1'b0, 2'd0, '0); step();
    exp_all(102, 2'd1, 3'd7, 3'd1, 4'h5); drain();
    drive(3'b000, 1'b1, 1'b0, 2'd0, '0); step();
    exp_all(103, 2'd0, 3'd7, 3'd0, 4'h9); drain();
    drive(3'b000, 1'b0, 1'b0, 2'd0, '0); step();
    exp_all(104, 2'd0, 3'd7, 3'd0, 4'h0); drain();

    // Reset while in DISPATCH aborts delivery.
    timer_pulse_to_pending();
    step();
    exp_all(200, 2'd1, 3'd7, 3'd1, 4'h5); drain();
    reset = 1'b1; step();
    exp_all(201, 2'd0, 3'd0, 3'd0, 4'h0); drain();
    reset = 1'b0;

    // W1C colliding with a new timer edge: the edge wins.
    drive(3'b001, 1'b0, 1'b0, 2'd0, '0); step();
    drive(3'b000, 1'b0, 1'b0, 2'd0, '0); step();
    drive(3'b000, 1'b0, 1'b1, 2'd1, 32'd1); step();
    exp_all(300, 2'd0, 3'd0, 3'd1, 4'h0); drain();
    drive(3'b000, 1'b0, 1'b1, 2'd1, 32'd1); step();
    exp_all(301, 2'd0, 3'd0, 3'd0, 4'h0); drain();

`ifdef IRQ_STATS_EN
    drive(3'b000, 1'b0, 1'b1, 2'd3, 32'hDEAD_BEEF); step();
    drive(3'b000, 1'b0, 1'b1, 2'd0, 32'd7); step();
    for (int n = 0; n < 2; n++) begin
      timer_pulse_to_pending();
      step();
      drive(3'b000, 1'b1, 1'b0, 2'd0, '0); step();
      drive(3'b000, 1'b0, 1'b0, 2'd0, '0); step();
    end
    exp_reg(400, 2'd3, 32'h0000_0002, 32'hFFFF_FFFF);
    exp_reg(401, 2'd2, 32'h0000_0000, 32'hFFFF_0000);
    drain();
    drive(3'b000, 1'b0, 1'b1, 2'd3, 32'd0); step();
    exp_reg(402, 2'd3, 32'h0000_0000, 32'hFFFF_FFFF);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
